// File: rtl/aho_run_ctrl.sv
// rtl/aho_run_ctrl.sv - AHO run controller: steps 1..LEN, flags multiples of 3/5/7, counts hits
module aho_run_ctrl #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [W-1:0] LEN,
   input  logic [2:0]   MASK,
   input  logic         ABORT,
   output logic         BUSY,
   output logic         STEP,
   output logic [W-1:0] IDX,
   output logic         HIT,
   output logic         DONE_VALID,
   input  logic         DONE_READY,
   output logic [W-1:0] HIT_CNT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_idx;
   logic [W-1:0] r_len;
   logic [2:0]   r_mask;
   logic [W-1:0] r_hit_cnt;
   logic [1:0]   r_r3;
   logic [2:0]   r_r5;
   logic [2:0]   r_r7;
   logic         w_run;
   logic         w_last;
   logic         w_hit;

   assign w_run  = (r_state == S_RUN);
   assign w_last = (r_idx == r_len);
   // Residues track IDX mod 3/5/7 incrementally, so a hit is just a zero test.
   assign w_hit  = w_run & |(r_mask & {(r_r7 == 3'd0), (r_r5 == 3'd0), (r_r3 == 2'd0)});

   assign BUSY       = (r_state != S_IDLE);
   assign STEP       = w_run;
   assign IDX        = r_idx;
   assign HIT        = w_hit;
   assign DONE_VALID = (r_state == S_DONE);
   assign HIT_CNT    = r_hit_cnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_nxt = (LEN == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (ABORT) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (DONE_READY) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_idx     <= '0;
         r_len     <= '0;
         r_mask    <= '0;
         r_hit_cnt <= '0;
         r_r3      <= '0;
         r_r5      <= '0;
         r_r7      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_hit_cnt <= '0;
                  if (LEN != '0) begin
                     r_len  <= LEN;
                     r_mask <= MASK;
                     r_idx  <= {{(W-1){1'b0}}, 1'b1};
                     r_r3   <= 2'd1;
                     r_r5   <= 3'd1;
                     r_r7   <= 3'd1;
                  end
               end
            end
            S_RUN: begin
               // An aborted cycle neither counts its hit nor advances the index.
               if (!ABORT) begin
                  r_hit_cnt <= r_hit_cnt + {{(W-1){1'b0}}, w_hit};
                  if (!w_last) begin
                     r_idx <= r_idx + {{(W-1){1'b0}}, 1'b1};
                     r_r3  <= (r_r3 == 2'd2) ? 2'd0 : r_r3 + 2'd1;
                     r_r5  <= (r_r5 == 3'd4) ? 3'd0 : r_r5 + 3'd1;
                     r_r7  <= (r_r7 == 3'd6) ? 3'd0 : r_r7 + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aho_run_ctrl.sv
// tb/tb_aho_run_ctrl.sv - randomized self-checking bench for aho_run_ctrl
module tb_aho_run_ctrl;
   localparam int W = 16;

   logic         CLK;
   logic         RST;
   logic         START;
   logic [W-1:0] LEN;
   logic [2:0]   MASK;
   logic         ABORT;
   logic         BUSY;
   logic         STEP;
   logic [W-1:0] IDX;
   logic         HIT;
   logic         DONE_VALID;
   logic         DONE_READY;
   logic [W-1:0] HIT_CNT;

   int n_vec = 0;
   int n_err = 0;

   aho_run_ctrl #(.W(W)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .LEN        (LEN),
      .MASK       (MASK),
      .ABORT      (ABORT),
      .BUSY       (BUSY),
      .STEP       (STEP),
      .IDX        (IDX),
      .HIT        (HIT),
      .DONE_VALID (DONE_VALID),
      .DONE_READY (DONE_READY),
      .HIT_CNT    (HIT_CNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_hit(input int i, input logic [2:0] m);
      return ((m[0] && (i % 3 == 0)) || (m[1] && (i % 5 == 0)) || (m[2] && (i % 7 == 0))) ? 1 : 0;
   endfunction

   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy"}, BUSY, 0);
      check_eq({tag, "_step"}, STEP, 0);
      check_eq({tag, "_idx"}, IDX, 0);
      check_eq({tag, "_hit"}, HIT, 0);
      check_eq({tag, "_dv"}, DONE_VALID, 0);
      check_eq({tag, "_cnt"}, HIT_CNT, 0);
   endtask

   // Called #1 after a rising edge with the DUT idle; returns in the same phase.
   task automatic run_one(input int len, input logic [2:0] mask, input int abort_at,
                          input int ready_dly, input bit poke_start);
      int cnt = 0;
      bit aborted = 0;
      START = 1'b1;
      LEN   = len[W-1:0];
      MASK  = mask;
      ABORT = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      START = 1'b0;
      ABORT = 1'b0;
      if (len == 0) check_eq("len0_step", STEP, 0);
      for (int i = 1; i <= len && !aborted; i++) begin
         check_eq("step", STEP, 1);
         check_eq("idx", IDX, i);
         check_eq("hit", HIT, exp_hit(i, mask));
         if (i == abort_at) begin
            ABORT = 1'b1;
            @(posedge CLK); #1;
            ABORT   = 1'b0;
            aborted = 1'b1;
            check_eq("abort_step", STEP, 0);
            check_eq("abort_busy", BUSY, 0);
            check_eq("abort_dv", DONE_VALID, 0);
            check_eq("abort_cnt", HIT_CNT, cnt);
         end else begin
            cnt += exp_hit(i, mask);
            @(posedge CLK); #1;
         end
      end
      if (!aborted) begin
         for (int d = 0; d <= ready_dly; d++) begin
            check_eq("dv", DONE_VALID, 1);
            check_eq("busy", BUSY, 1);
            check_eq("done_step", STEP, 0);
            check_eq("cnt", HIT_CNT, cnt);
            if (d == ready_dly) begin
               DONE_READY = 1'b1;
            end else if (poke_start && d == 0) begin
               START = 1'b1;
               LEN   = 16'd5;
            end
            @(posedge CLK); #1;
            DONE_READY = 1'b0;
            START      = 1'b0;
         end
         check_eq("post_dv", DONE_VALID, 0);
         check_eq("post_busy", BUSY, 0);
         check_eq("post_step", STEP, 0);
         check_eq("post_cnt", HIT_CNT, cnt);
      end
   endtask

   task automatic run_reset(input int len, input int rst_at);
      START = 1'b1;
      LEN   = len[W-1:0];
      MASK  = 3'b111;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int i = 1; i < rst_at; i++) begin
         check_eq("rst_run_idx", IDX, i);
         @(posedge CLK); #1;
      end
      #2 RST = 1'b0;
      #1 check_quiet("async_rst");
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      check_quiet("after_rst");
   endtask

   initial begin
      RST        = 1'b0;
      START      = 1'b0;
      LEN        = '0;
      MASK       = '0;
      ABORT      = 1'b0;
      DONE_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1 check_quiet("reset");
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      check_quiet("idle");

      run_one(15, 3'b111, 0, 0, 1'b0);
      run_one(15, 3'b010, 0, 1, 1'b0);
      run_one(15, 3'b000, 0, 0, 1'b0);
      run_one(0, 3'b111, 0, 2, 1'b0);
      run_one(10, 3'b111, 0, 5, 1'b1);
      run_one(20, 3'b111, 8, 0, 1'b0);
      run_one(20, 3'b111, 0, 0, 1'b0);
      run_one(7, 3'b100, 7, 0, 1'b0);
      run_one(1, 3'b111, 0, 0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         int len;
         int ab;
         len = int'($urandom_range(0, 40));
         ab  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
         run_one(len, 3'($urandom_range(0, 7)), ab, int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)));
      end

      run_one(65535, 3'b001, 0, 1, 1'b0);
      run_reset(100, 50);
      run_one(12, 3'b011, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
